// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential PCs to a variable-latency memory,
// queues returned words with their PCs and hands them to decode over valid/ready.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_pc2,
    input  logic        inst_ready,
    output logic        halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD, HALTED} state_t;

    state_t          state, state_nxt;
    logic [15:0]     pc;
    logic [15:0]     req_pc;
    logic [15:0]     fifo_inst [DEPTH];
    logic [15:0]     fifo_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic            halt_seen;
    logic            outstanding;
    logic            accept;
    logic            push;
    logic            pop;

    assign outstanding = (state == WAIT) || (state == DISCARD);
    assign occupancy   = count + CW'(outstanding);
    assign imem_req    = (state == FETCH) && !halt_seen && (occupancy < CW'(DEPTH));
    assign imem_addr   = pc;
    assign accept      = imem_req && !imem_stall;
    // A word returning in the same cycle as a redirect belongs to the old path.
    assign push        = (state == WAIT) && imem_done && !redirect_valid;
    assign pop         = inst_valid && inst_ready;

    assign inst_valid  = (count != '0);
    assign inst        = inst_valid ? fifo_inst[rd_ptr] : 16'h0800;
    assign inst_pc     = inst_valid ? fifo_pc[rd_ptr] : 16'h0000;
    assign inst_pc2    = inst_pc + 16'd2;
    assign halted      = halt_seen && (count == '0) && !outstanding;

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // Any request still in flight must have its data thrown away.
            state_nxt = ((outstanding && !imem_done) || accept) ? DISCARD : FETCH;
        end else begin
            case (state)
                FETCH:   begin
                    if (accept)
                        state_nxt = WAIT;
                    else if (halt_seen && (count == '0))
                        state_nxt = HALTED;
                end
                WAIT:    if (imem_done) state_nxt = FETCH;
                DISCARD: if (imem_done) state_nxt = FETCH;
                HALTED:  state_nxt = HALTED;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            halt_seen <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc        <= {redirect_pc[15:1], 1'b0};
                halt_seen <= 1'b0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
            end else begin
                if (accept)
                    pc <= pc + 16'd2;
                if (push && (imem_data[15:11] == 5'b00000))
                    halt_seen <= 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage only; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (accept)
            req_pc <= pc;
        if (push) begin
            fifo_inst[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle table for the main sequences plus
// memory-model driven sequences for backpressure and stall handling.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc2;
    logic        inst_ready;
    logic        halted;

    fetch_queue #(.DEPTH(4), .PC_RESET(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_stall(imem_stall), .imem_done(imem_done), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc2(inst_pc2),
        .inst_ready(inst_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [15:0] rpc;
        logic        stall;
        logic        done;
        logic [15:0] data;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_iv;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        logic        e_halt;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    logic        s_req, s_iv, s_acc;
    logic [15:0] s_addr, s_inst, s_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of a 1-cycle-latency memory returning 16'h4000|addr.
    task automatic mem_cycle(input logic st, input logic rd);
        @(negedge clk);
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        imem_stall     = st;
        inst_ready     = rd;
        imem_done      = pend;
        imem_data      = 16'h4000 | pend_addr;
        #1;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_iv   = inst_valid;
        s_inst = inst;
        s_pc   = inst_pc;
        s_acc  = imem_req && !st;
        @(posedge clk);
        pend      = s_acc;
        pend_addr = s_addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_stall     = 1'b1;
        imem_done      = 1'b0;
        inst_ready     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pend  = 1'b0;
    endtask

    initial begin
        int          n_acc;
        int          got;
        logic [15:0] addrs [4];

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        imem_stall = 1'b0; imem_done = 1'b0; imem_data = 16'h0; inst_ready = 1'b0;

        // rst_n rv rpc stall done data ready | req addr iv inst pc halted
        vq.push_back('{0,0,16'h0000,0,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{0,0,16'h0000,0,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        // in-order streaming, ready held high
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4001,1, 0,16'h0002,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 1,16'h0002,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4202,1, 0,16'h0004,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 1,16'h0004,1,16'h4202,16'h0002,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4403,1, 0,16'h0006,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 1,16'h0006,1,16'h4403,16'h0004,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4604,1, 0,16'h0008,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,1,0,16'h0000,1, 1,16'h0008,1,16'h4604,16'h0006,0});
        // redirect while the fetch at 4 is outstanding
        vq.push_back('{0,0,16'h0000,0,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4001,0, 0,16'h0002,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0002,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4202,0, 0,16'h0004,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0004,1,16'h4001,16'h0000,0});
        vq.push_back('{1,1,16'h0101,0,0,16'h0000,0, 0,16'h0006,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4403,0, 0,16'h0100,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,1,0,16'h0000,0, 1,16'h0100,0,16'h0800,16'h0000,0});
        // async reset in WAIT with two entries queued, then a stray done
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0100,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h5000,0, 0,16'h0102,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0102,1,16'h5000,16'h0100,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h5100,0, 0,16'h0104,1,16'h5000,16'h0100,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0104,1,16'h5000,16'h0100,0});
        vq.push_back('{0,0,16'h0000,0,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,1,1,16'h6000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,1,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        // HALT word at pc 6, drain, resume by redirect
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0000,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4001,0, 0,16'h0002,0,16'h0800,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0002,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4202,0, 0,16'h0004,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0004,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h4403,0, 0,16'h0006,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 1,16'h0006,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,1,16'h0000,0, 0,16'h0008,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 0,16'h0008,1,16'h4001,16'h0000,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 0,16'h0008,1,16'h4202,16'h0002,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 0,16'h0008,1,16'h4403,16'h0004,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,1, 0,16'h0008,1,16'h0000,16'h0006,0});
        vq.push_back('{1,0,16'h0000,0,0,16'h0000,0, 0,16'h0008,0,16'h0800,16'h0000,1});
        vq.push_back('{1,1,16'h0020,0,0,16'h0000,0, 0,16'h0008,0,16'h0800,16'h0000,1});
        vq.push_back('{1,0,16'h0000,1,0,16'h0000,0, 1,16'h0020,0,16'h0800,16'h0000,0});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n          = vq[i].rst_n;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            imem_stall     = vq[i].stall;
            imem_done      = vq[i].done;
            imem_data      = vq[i].data;
            inst_ready     = vq[i].ready;
            #1;
            chk($sformatf("row%0d_req", i),    imem_req,   vq[i].e_req);
            chk($sformatf("row%0d_addr", i),   imem_addr,  vq[i].e_addr);
            chk($sformatf("row%0d_valid", i),  inst_valid, vq[i].e_iv);
            chk($sformatf("row%0d_inst", i),   inst,       vq[i].e_inst);
            chk($sformatf("row%0d_pc", i),     inst_pc,    vq[i].e_pc);
            chk($sformatf("row%0d_pc2", i),    inst_pc2,   vq[i].e_pc + 16'd2);
            chk($sformatf("row%0d_halted", i), halted,     vq[i].e_halt);
        end

        // backpressure: four accepts then stall the front end until decode pops
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 16; c++) begin
            mem_cycle(1'b0, 1'b0);
            if (s_acc) begin
                if (n_acc < 4) addrs[n_acc] = s_addr;
                n_acc++;
            end
        end
        chk("bp_accepts", n_acc, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_addr%0d", k), addrs[k], 16'(2 * k));
        chk("bp_req_idle", s_req, 1'b0);
        mem_cycle(1'b0, 1'b1);
        chk("bp_pop_valid", s_iv, 1'b1);
        chk("bp_pop_pc", s_pc, 16'h0000);
        got = 0;
        for (int c = 0; c < 8 && got == 0; c++) begin
            mem_cycle(1'b0, 1'b0);
            if (s_acc) begin
                got = 1;
                chk("bp_next_addr", s_addr, 16'h0008);
                chk("bp_next_head", s_pc, 16'h0002);
            end
        end
        chk("bp_next_accept", got, 1);

        // memory stall at addr 2 for three cycles
        do_reset();
        mem_cycle(1'b0, 1'b0);
        chk("st_acc0", s_acc, 1'b1);
        chk("st_addr0", s_addr, 16'h0000);
        mem_cycle(1'b0, 1'b0);
        chk("st_wait_req", s_req, 1'b0);
        for (int c = 0; c < 3; c++) begin
            mem_cycle(1'b1, 1'b0);
            chk($sformatf("st_hold_req%0d", c), s_req, 1'b1);
            chk($sformatf("st_hold_addr%0d", c), s_addr, 16'h0002);
        end
        mem_cycle(1'b0, 1'b0);
        chk("st_acc1", s_acc, 1'b1);
        chk("st_addr1", s_addr, 16'h0002);
        mem_cycle(1'b1, 1'b1);
        chk("st_head0_pc", s_pc, 16'h0000);
        chk("st_head0_inst", s_inst, 16'h4000);
        mem_cycle(1'b1, 1'b1);
        chk("st_head1_valid", s_iv, 1'b1);
        chk("st_head1_pc", s_pc, 16'h0002);
        chk("st_head1_inst", s_inst, 16'h4002);
        mem_cycle(1'b1, 1'b0);
        chk("st_no_dup", s_iv, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
